// File: rtl/pid_encoder_error.sv
// Per-channel x4 quadrature decoders, setpoint bank and saturated error (setpoint - position) for the channel on `a`.
// Latency: encoder edge reaches position 3 clk after sampling; error/pos_out/glitch_out are registered (1 clk); no backpressure.
module pid_encoder_error #(
    parameter int aw = 1,
    parameter int an = 1 << aw,
    parameter int ew = 24,
    parameter int gw = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [aw-1:0] a,
    output logic [ew-1:0] error,
    input  logic [an-1:0] enc_a,
    input  logic [an-1:0] enc_b,
    input  logic          sp_we,
    input  logic [aw-1:0] sp_addr,
    input  logic [ew-1:0] sp_data,
    input  logic [an-1:0] pos_clr,
    output logic [ew-1:0] pos_out,
    output logic [gw-1:0] glitch_out
);

    logic [an-1:0] a_s1, a_s2, a_prev;
    logic [an-1:0] b_s1, b_s2, b_prev;

    logic [ew-1:0] position [an];
    logic [ew-1:0] setpoint [an];
    logic [gw-1:0] glitch   [an];

    logic [an-1:0] step_inc, step_dec, step_bad;

    logic [ew:0]   diff;
    logic [ew-1:0] err_sat;

    // Gray order 00,10,11,01 mapped to 0..3 so a mod-4 difference gives direction.
    function automatic logic [1:0] phase_idx(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    always_comb begin
        step_inc = '0;
        step_dec = '0;
        step_bad = '0;
        for (int i = 0; i < an; i++) begin
            logic [1:0] delta;
            delta = phase_idx({a_s2[i], b_s2[i]}) - phase_idx({a_prev[i], b_prev[i]});
            step_inc[i] = (delta == 2'd1);
            step_dec[i] = (delta == 2'd3);
            step_bad[i] = (delta == 2'd2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_s1   <= '0;
            a_s2   <= '0;
            a_prev <= '0;
            b_s1   <= '0;
            b_s2   <= '0;
            b_prev <= '0;
        end else begin
            a_s1   <= enc_a;
            a_s2   <= a_s1;
            a_prev <= a_s2;
            b_s1   <= enc_b;
            b_s2   <= b_s1;
            b_prev <= b_s2;
        end
    end

    // Previous-phase flops keep tracking during clear, so release never produces a count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < an; i++) begin
                position[i] <= '0;
                glitch[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < an; i++) begin
                if (pos_clr[i]) begin
                    position[i] <= '0;
                    glitch[i]   <= '0;
                end else begin
                    if (step_inc[i])
                        position[i] <= position[i] + ew'(1);
                    else if (step_dec[i])
                        position[i] <= position[i] - ew'(1);
                    if (step_bad[i] && (glitch[i] != {gw{1'b1}}))
                        glitch[i] <= glitch[i] + gw'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < an; i++)
                setpoint[i] <= '0;
        end else if (sp_we) begin
            setpoint[sp_addr] <= sp_data;
        end
    end

    always_comb begin
        diff = {setpoint[a][ew-1], setpoint[a]} - {position[a][ew-1], position[a]};
        if (diff[ew] != diff[ew-1])
            err_sat = diff[ew] ? {1'b1, {(ew-1){1'b0}}} : {1'b0, {(ew-1){1'b1}}};
        else
            err_sat = diff[ew-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error      <= '0;
            pos_out    <= '0;
            glitch_out <= '0;
        end else begin
            error      <= err_sat;
            pos_out    <= position[sp_addr];
            glitch_out <= glitch[sp_addr];
        end
    end

endmodule

// File: tb/tb_pid_encoder_error.sv
// Directed bench for pid_encoder_error: decode, latency, saturation, glitches, clear race and async reset.
module tb_pid_encoder_error;

    logic        clk;
    logic        reset;
    logic [0:0]  a;
    logic [23:0] error;
    logic [1:0]  enc_a;
    logic [1:0]  enc_b;
    logic        sp_we;
    logic [0:0]  sp_addr;
    logic [23:0] sp_data;
    logic [1:0]  pos_clr;
    logic [23:0] pos_out;
    logic [7:0]  glitch_out;

    int checks = 0;
    int errors = 0;
    logic [1:0] ph [2];

    pid_encoder_error #(.aw(1), .ew(24), .gw(8)) dut (
        .clk(clk), .reset(reset), .a(a), .error(error),
        .enc_a(enc_a), .enc_b(enc_b),
        .sp_we(sp_we), .sp_addr(sp_addr), .sp_data(sp_data),
        .pos_clr(pos_clr), .pos_out(pos_out), .glitch_out(glitch_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] p, input bit fwd);
        logic [1:0] r;
        if (fwd)
            case (p)
                2'b00:   r = 2'b10;
                2'b10:   r = 2'b11;
                2'b11:   r = 2'b01;
                default: r = 2'b00;
            endcase
        else
            case (p)
                2'b00:   r = 2'b01;
                2'b01:   r = 2'b11;
                2'b11:   r = 2'b10;
                default: r = 2'b00;
            endcase
        return r;
    endfunction

    task automatic setph(input int ch, input logic [1:0] v, input int hold);
        ph[ch] = v;
        enc_a[ch] = v[1];
        enc_b[ch] = v[0];
        tick(hold);
    endtask

    task automatic steps(input int ch, input bit fwd, input int n);
        for (int k = 0; k < n; k++)
            setph(ch, nxt(ph[ch], fwd), 4);
    endtask

    task automatic wrsp(input logic [0:0] ch, input logic [23:0] v);
        sp_we = 1'b1;
        sp_addr = ch;
        sp_data = v;
        tick(1);
        sp_we = 1'b0;
    endtask

    task automatic clr(input logic [1:0] m);
        pos_clr = m;
        tick(1);
        pos_clr = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        a = '0; enc_a = '0; enc_b = '0;
        sp_we = 1'b0; sp_addr = '0; sp_data = '0; pos_clr = '0;
        ph[0] = 2'b00; ph[1] = 2'b00;
        tick(2);
        check("rst_error", error, 24'h0);
        check("rst_pos", pos_out, 24'h0);
        check("rst_glitch", {16'h0, glitch_out}, 24'h0);
        reset = 1'b0;
        tick(2);

        // 20 forward, 8 reverse on ch0
        steps(0, 1'b1, 20);
        tick(1);
        check("fwd20_pos", pos_out, 24'd20);
        steps(0, 1'b0, 8);
        tick(1);
        check("rev8_pos", pos_out, 24'd12);
        check("rev8_glitch", {16'h0, glitch_out}, 24'h0);
        check("rev8_error", error, 24'hFFFFF4);

        // decode latency: position moves on the 3rd edge, readback on the 4th
        setph(0, 2'b10, 3);
        check("lat3_pos", pos_out, 24'd12);
        check("lat3_err", error, 24'hFFFFF4);
        tick(1);
        check("lat4_pos", pos_out, 24'd13);
        check("lat4_err", error, 24'hFFFFF3);
        steps(0, 1'b0, 1);
        clr(2'b01);

        // ch1 setpoint 1000, +300 counts
        wrsp(1'b1, 24'd1000);
        steps(1, 1'b1, 300);
        a = 1'b1;
        tick(2);
        check("ch1_error", error, 24'd700);
        check("ch1_pos", pos_out, 24'd300);
        a = 1'b0;
        tick(1);
        check("ch0_error_zero", error, 24'h0);

        // setpoint written at edge N shows on error after edge N+1
        wrsp(1'b0, 24'd5);
        check("sp_lat_old", error, 24'h0);
        tick(1);
        check("sp_lat_new", error, 24'd5);

        // saturation
        wrsp(1'b0, 24'h7FFFFF);
        steps(0, 1'b0, 5);
        tick(1);
        check("sat_pos_pos", pos_out, 24'hFFFFFB);
        check("sat_pos_err", error, 24'h7FFFFF);
        wrsp(1'b0, 24'h800000);
        tick(1);
        check("nosat_err", error, 24'h800005);
        steps(0, 1'b1, 10);
        tick(1);
        check("sat_neg_pos", pos_out, 24'd5);
        check("sat_neg_err", error, 24'h800000);

        // illegal transitions on ch0 (phase is 10 here)
        clr(2'b01);
        setph(0, 2'b01, 4);
        setph(0, 2'b10, 4);
        setph(0, 2'b01, 4);
        setph(0, 2'b10, 4);
        tick(1);
        check("gl4_count", {16'h0, glitch_out}, 24'd4);
        check("gl4_pos", pos_out, 24'h0);
        setph(0, 2'b00, 4);
        setph(0, 2'b11, 4);
        setph(0, 2'b00, 4);
        tick(1);
        check("gl6_count", {16'h0, glitch_out}, 24'd6);
        check("gl6_pos", pos_out, 24'hFFFFFF);
        for (int k = 0; k < 150; k++) begin
            setph(0, 2'b11, 2);
            setph(0, 2'b00, 2);
        end
        tick(4);
        check("gl_sat", {16'h0, glitch_out}, 24'd255);
        check("gl_sat_pos", pos_out, 24'hFFFFFF);

        // ch1: glitches, then clear racing a +1 decode
        sp_addr = 1'b1;
        setph(1, 2'b11, 4);
        setph(1, 2'b00, 4);
        check("ch1_gl2", {16'h0, glitch_out}, 24'd2);
        check("ch1_pos300", pos_out, 24'd300);
        setph(1, 2'b10, 2);
        pos_clr = 2'b10;
        tick(1);
        pos_clr = 2'b00;
        tick(1);
        check("clr_pos", pos_out, 24'h0);
        check("clr_glitch", {16'h0, glitch_out}, 24'h0);
        tick(4);
        check("clr_nospur", pos_out, 24'h0);
        sp_addr = 1'b0;
        tick(2);
        check("clr_ch0_kept", pos_out, 24'hFFFFFF);

        // async reset mid-count
        clr(2'b01);
        wrsp(1'b0, 24'd100);
        setph(0, 2'b11, 4);
        setph(0, 2'b00, 4);
        steps(0, 1'b1, 57);
        tick(1);
        check("pre_rst_pos", pos_out, 24'd57);
        check("pre_rst_err", error, 24'd43);
        check("pre_rst_gl", {16'h0, glitch_out}, 24'd2);
        setph(0, nxt(ph[0], 1'b1), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_err", error, 24'h0);
        check("arst_pos", pos_out, 24'h0);
        check("arst_gl", {16'h0, glitch_out}, 24'h0);
        enc_a = '0; enc_b = '0;
        ph[0] = 2'b00; ph[1] = 2'b00;
        tick(2);
        reset = 1'b0;
        tick(1);
        steps(0, 1'b1, 3);
        tick(1);
        check("post_rst_pos", pos_out, 24'd3);
        check("post_rst_err", error, 24'hFFFFFD);
        check("post_rst_gl", {16'h0, glitch_out}, 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
